// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write arbiter: FSM encoding, default
// parameter values and a small width helper.
package fifo_arb_pkg;

   localparam int NUM_REQ_DEF   = 4;
   localparam int DATA_W_DEF    = 8;
   localparam int MAX_BURST_DEF = 8;

   // FSM encoding kept as plain constants so older tooling can read it
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   // Width of a requester index; never narrower than one bit
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester/FIFO-side bundle of the write arbiter. The arbiter uses the
// slave view; whatever drives the requesters and watches the FIFO port
// uses the master view.
interface fifo_write_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DATA_W  = DATA_W_DEF
) ();

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_last;
   logic                      fifo_full;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        ack;
   logic                      write_en;
   logic [DATA_W-1:0]         data_out;
   logic                      busy;
   logic [15:0]               stall_cnt;

   modport master (
      output req, req_data, req_last, fifo_full,
      input  gnt, ack, write_en, data_out, busy, stall_cnt
   );

   modport slave (
      input  req, req_data, req_last, fifo_full,
      output gnt, ack, write_en, data_out, busy, stall_cnt
   );

endinterface

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Round-robin winner search. Scans from the requester after last_winner,
// wrapping around, and reports the first active request both as a one-hot
// vector and as an index. Purely combinational.
module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_winner,
   output logic [NUM_REQ-1:0] winner,
   output logic [IDX_W-1:0]   winner_idx
);

   logic found;

   // Walk the rotated request vector and keep the first hit
   always_comb begin
      int j;
      winner     = '0;
      winner_idx = '0;
      found      = 1'b0;
      j          = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         j = (int'(last_winner) + k) % NUM_REQ;
         if (!found && req[j]) begin
            found      = 1'b1;
            winner[j]  = 1'b1;
            winner_idx = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one FIFO write port between NUM_REQ requesters. A round-robin
// winner is chosen in IDLE and owns the port for a burst that ends on its
// last-beat marker, on MAX_BURST accepted beats, or when it drops req.
// Every release goes back through IDLE so arbitration always sees a fresh
// request vector.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = NUM_REQ_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic          clk,
   input  logic          reset,
   fifo_write_arbiter_if.slave bus
);

   localparam int IDX_W = idx_width(NUM_REQ);
   localparam int BC_W  = $clog2(MAX_BURST + 1);

   logic [0:0]         state_reg;
   logic [NUM_REQ-1:0] gnt_reg;
   logic [IDX_W-1:0]   gnt_idx_reg;
   logic [IDX_W-1:0]   last_winner_reg;
   logic [BC_W-1:0]    beat_cnt_reg;
   logic [15:0]        stall_cnt_reg;

   logic [NUM_REQ-1:0] pick_onehot;
   logic [IDX_W-1:0]   pick_idx;
   logic               in_burst;
   logic               owner_req;
   logic               accept;
   logic [BC_W-1:0]    beat_next;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req         (bus.req),
      .last_winner (last_winner_reg),
      .winner      (pick_onehot),
      .winner_idx  (pick_idx)
   );

   assign in_burst  = (state_reg == ST_BURST);
   assign owner_req = bus.req[gnt_idx_reg];
   // A beat moves only when the owner still has data and the FIFO has room;
   // with reset low state is already IDLE, so nothing leaks out.
   assign accept    = in_burst && owner_req && !bus.fifo_full;
   assign beat_next = beat_cnt_reg + 1'b1;

   assign bus.gnt       = gnt_reg;
   assign bus.busy      = in_burst;
   assign bus.stall_cnt = stall_cnt_reg;
   assign bus.write_en  = accept;
   assign bus.ack       = accept ? gnt_reg : '0;
   assign bus.data_out  = accept ? bus.req_data[gnt_idx_reg*DATA_W +: DATA_W] : '0;

   // Arbitration, burst bookkeeping, release and stall accounting
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= ST_IDLE;
         gnt_reg         <= '0;
         gnt_idx_reg     <= '0;
         last_winner_reg <= IDX_W'(NUM_REQ - 1);
         beat_cnt_reg    <= '0;
         stall_cnt_reg   <= '0;
      end else if (state_reg == ST_IDLE) begin
         if (|bus.req) begin
            state_reg    <= ST_BURST;
            gnt_reg      <= pick_onehot;
            gnt_idx_reg  <= pick_idx;
            beat_cnt_reg <= '0;
         end
      end else begin
         if (!owner_req) begin
            // Owner ran dry: give the port back even if the FIFO is full
            state_reg       <= ST_IDLE;
            gnt_reg         <= '0;
            last_winner_reg <= gnt_idx_reg;
         end else if (bus.fifo_full) begin
            // Grant is held; only the stall statistic moves
            if (stall_cnt_reg != 16'hFFFF) begin
               stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
         end else begin
            beat_cnt_reg <= beat_next;
            if (bus.req_last[gnt_idx_reg] || (beat_next == BC_W'(MAX_BURST))) begin
               state_reg       <= ST_IDLE;
               gnt_reg         <= '0;
               last_winner_reg <= gnt_idx_reg;
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scenario bench for fifo_write_arbiter. Tasks drive stimulus one cycle at
// a time (inputs change 1 time unit after the rising edge, outputs are
// examined on the falling edge) and push every beat they expect the DUT to
// accept into a queue; a falling-edge monitor pops and compares each beat.
module tb_fifo_write_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int MB = 8;

   typedef struct {
      int          idx;
      logic [DW-1:0] data;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   exp_t          sb_q[$];
   exp_t          mon_e;
   logic [NR-1:0] mon_ack;

   fifo_write_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

   fifo_write_arbiter #(
      .NUM_REQ   (NR),
      .DATA_W    (DW),
      .MAX_BURST (MB)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: every write_en pulse must match the oldest expected beat
   always @(negedge clk) begin
      if (bus.write_en === 1'b1) begin
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_beat: got ack=%b data_out=%h, required no beat", bus.ack, bus.data_out);
         end else begin
            mon_e   = sb_q.pop_front();
            mon_ack = 4'b0001 << mon_e.idx;
            if (bus.data_out !== mon_e.data || bus.ack !== mon_ack) begin
               bad++;
               $display("FAIL sb_beat: got ack=%b data_out=%h, required ack=%b data_out=%h",
                        bus.ack, bus.data_out, mon_ack, mon_e.data);
            end else begin
               $display("beat ok: requester=%0d data=%h", mon_e.idx, mon_e.data);
            end
         end
      end else begin
         total++;
         if (bus.ack !== '0 || bus.data_out !== '0) begin
            bad++;
            $display("FAIL no_beat_outputs: got ack=%b data_out=%h, required 0 and 0", bus.ack, bus.data_out);
         end
      end
   end

   task automatic test_reset();
      #1 reset = 1'b0;
      #1;
      total++;
      if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.write_en !== 1'b0 || bus.stall_cnt !== 16'd0) begin
         bad++;
         $display("FAIL reset_state: got gnt=%b busy=%b we=%b stall=%0d, required 0 0 0 0",
                  bus.gnt, bus.busy, bus.write_en, bus.stall_cnt);
      end
      $display("reset: gnt=%b busy=%b stall=%0d", bus.gnt, bus.busy, bus.stall_cnt);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_round_robin();
      int w;
      logic [DW-1:0] d;
      for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = DW'($urandom);
      bus.req_last = '1;
      bus.req      = '1;
      for (int n = 0; n < 5; n++) begin
         w = n % NR;
         @(posedge clk);
         #1 d = bus.req_data[w*DW +: DW];
         sb_q.push_back('{idx: w, data: d});
         @(negedge clk);
         total++;
         if (bus.gnt !== (4'b0001 << w) || bus.write_en !== 1'b1) begin
            bad++;
            $display("FAIL rr_grant: got gnt=%b we=%b, required gnt=%b we=1", bus.gnt, bus.write_en, 4'b0001 << w);
         end
         $display("rr grant %0d: gnt=%b", n, bus.gnt);
         @(posedge clk);
         #1 if (n == 4) bus.req = '0;
         @(negedge clk);
         total++;
         if (bus.gnt !== '0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL rr_idle_gap: got gnt=%b busy=%b, required 0 0", bus.gnt, bus.busy);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_max_burst();
      logic [DW-1:0] d;
      bus.req_last = '0;
      bus.req      = 4'b0100;
      @(posedge clk);
      for (int b = 0; b < MB; b++) begin
         #1 d = DW'($urandom);
         bus.req_data[2*DW +: DW] = d;
         sb_q.push_back('{idx: 2, data: d});
         @(negedge clk);
         total++;
         if (bus.write_en !== 1'b1 || bus.gnt !== 4'b0100) begin
            bad++;
            $display("FAIL mb_beat%0d: got we=%b gnt=%b, required we=1 gnt=0100", b, bus.write_en, bus.gnt);
         end
         @(posedge clk);
      end
      #1;
      @(negedge clk);
      total++;
      if (bus.gnt !== '0 || bus.write_en !== 1'b0) begin
         bad++;
         $display("FAIL mb_release: got gnt=%b we=%b after %0d beats, required gnt=0000 we=0", bus.gnt, bus.write_en, MB);
      end
      $display("max burst: released after %0d beats", MB);
      @(posedge clk);
      #1 d = bus.req_data[2*DW +: DW];
      sb_q.push_back('{idx: 2, data: d});
      @(negedge clk);
      total++;
      if (bus.gnt !== 4'b0100) begin
         bad++;
         $display("FAIL mb_regrant: got gnt=%b, required 0100", bus.gnt);
      end
      @(posedge clk);
      #1 bus.req = '0;
      @(negedge clk);
      total++;
      if (bus.write_en !== 1'b0 || bus.gnt !== 4'b0100) begin
         bad++;
         $display("FAIL mb_drop: got we=%b gnt=%b, required we=0 gnt=0100", bus.write_en, bus.gnt);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_fifo_full();
      logic [DW-1:0] d;
      bus.req_last  = 4'b0010;
      bus.fifo_full = 1'b1;
      bus.req       = 4'b0010;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (bus.write_en !== 1'b0 || bus.gnt !== 4'b0010) begin
            bad++;
            $display("FAIL ff_hold%0d: got we=%b gnt=%b, required we=0 gnt=0010", i, bus.write_en, bus.gnt);
         end
         @(posedge clk);
      end
      #1 bus.fifo_full = 1'b0;
      d = bus.req_data[1*DW +: DW];
      sb_q.push_back('{idx: 1, data: d});
      @(negedge clk);
      total++;
      if (bus.stall_cnt !== 16'd5 || bus.write_en !== 1'b1) begin
         bad++;
         $display("FAIL ff_resume: got stall=%0d we=%b, required stall=5 we=1", bus.stall_cnt, bus.write_en);
      end
      $display("fifo full: stall_cnt=%0d", bus.stall_cnt);
      @(posedge clk);
      #1 bus.req = '0;
      @(negedge clk);
      total++;
      if (bus.gnt !== '0 || bus.stall_cnt !== 16'd5) begin
         bad++;
         $display("FAIL ff_release: got gnt=%b stall=%0d, required gnt=0000 stall=5", bus.gnt, bus.stall_cnt);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_drop_req();
      logic [DW-1:0] d;
      bus.req_last = '0;
      bus.req      = 4'b1000;
      @(posedge clk);
      for (int b = 0; b < 2; b++) begin
         #1 d = DW'($urandom);
         bus.req_data[3*DW +: DW] = d;
         sb_q.push_back('{idx: 3, data: d});
         @(negedge clk);
         total++;
         if (bus.gnt !== 4'b1000 || bus.write_en !== 1'b1) begin
            bad++;
            $display("FAIL dr_beat%0d: got gnt=%b we=%b, required gnt=1000 we=1", b, bus.gnt, bus.write_en);
         end
         @(posedge clk);
      end
      #1 bus.req = 4'b0011;
      bus.req_last = 4'b0001;
      @(negedge clk);
      total++;
      if (bus.write_en !== 1'b0 || bus.gnt !== 4'b1000) begin
         bad++;
         $display("FAIL dr_drop: got we=%b gnt=%b, required we=0 gnt=1000", bus.write_en, bus.gnt);
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if (bus.gnt !== '0) begin
         bad++;
         $display("FAIL dr_release: got gnt=%b, required 0000", bus.gnt);
      end
      @(posedge clk);
      #1 d = bus.req_data[0 +: DW];
      sb_q.push_back('{idx: 0, data: d});
      @(negedge clk);
      total++;
      if (bus.gnt !== 4'b0001) begin
         bad++;
         $display("FAIL dr_next_winner: got gnt=%b, required 0001", bus.gnt);
      end
      $display("drop req: next gnt=%b", bus.gnt);
      @(posedge clk);
      #1 bus.req = '0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_burst();
      logic [DW-1:0] d;
      bus.req_last = '0;
      bus.req      = 4'b0100;
      @(posedge clk);
      for (int b = 0; b < 3; b++) begin
         #1 d = bus.req_data[2*DW +: DW];
         sb_q.push_back('{idx: 2, data: d});
         @(negedge clk);
         @(posedge clk);
      end
      #1;
      total++;
      if (bus.write_en !== 1'b1) begin
         bad++;
         $display("FAIL rm_beat4_pending: got we=%b, required 1", bus.write_en);
      end
      reset = 1'b0;
      #1;
      total++;
      if (bus.write_en !== 1'b0 || bus.ack !== '0 || bus.busy !== 1'b0 || bus.gnt !== '0 || bus.stall_cnt !== 16'd0) begin
         bad++;
         $display("FAIL rm_async_clear: got we=%b ack=%b busy=%b gnt=%b stall=%0d, required all 0",
                  bus.write_en, bus.ack, bus.busy, bus.gnt, bus.stall_cnt);
      end
      $display("reset mid burst: we=%b gnt=%b stall=%0d", bus.write_en, bus.gnt, bus.stall_cnt);
      @(posedge clk);
      #1 bus.req = 4'b0110;
      bus.req_last = 4'b0110;
      reset = 1'b1;
      @(posedge clk);
      #1 d = bus.req_data[1*DW +: DW];
      sb_q.push_back('{idx: 1, data: d});
      @(negedge clk);
      total++;
      if (bus.gnt !== 4'b0010) begin
         bad++;
         $display("FAIL rm_first_grant: got gnt=%b, required 0010", bus.gnt);
      end
      @(posedge clk);
      #1 bus.req = '0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_scoreboard();
      int exp_last;
      int w;
      logic [NR-1:0] reqv;
      logic [DW-1:0] d;
      exp_last     = 1;  // requester 1 held the last grant in the previous scenario
      bus.req_last = '1;
      for (int n = 0; n < 32; n++) begin
         reqv = NR'($urandom_range(1, 15));
         for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = DW'($urandom);
         w = -1;
         for (int k = 1; k <= NR; k++) begin
            if (w < 0 && reqv[(exp_last + k) % NR]) w = (exp_last + k) % NR;
         end
         bus.req = reqv;
         @(posedge clk);
         #1 d = bus.req_data[w*DW +: DW];
         sb_q.push_back('{idx: w, data: d});
         @(negedge clk);
         total++;
         if (bus.gnt !== (4'b0001 << w)) begin
            bad++;
            $display("FAIL sb_rr%0d: got gnt=%b for req=%b, required %b", n, bus.gnt, reqv, 4'b0001 << w);
         end
         @(posedge clk);
         #1 exp_last = w;
      end
      bus.req = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: got %0d beats outstanding, required 0", sb_q.size());
      end
   endtask

   initial begin
      bus.req       = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      bus.fifo_full = 1'b0;
      test_reset();
      test_round_robin();
      test_max_burst();
      test_fifo_full();
      test_drop_req();
      test_reset_mid_burst();
      test_scoreboard();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "timeout");
   end

endmodule
